oram_request_arbiter: RTL and testbench
=======================================

// Module: oram_request_arbiter
// PURPOSE
//  Shares one oram_module between NUM_REQ requesters under round-robin arbitration.
//  Accepts one read/write per requester via valid/ready, drives the ORAM input_ready
//  pulse, and captures r_value on output_ready. Returns the data to the granted requester.
//  Sits between client logic and the ORAM core; one transaction is outstanding at a time.
// PARAMETERS
//  NUM_REQ   4                               number of requesters (2..8)
//  ADDR_W    TREE_DEPTH                      block-number width, from oram_functions_pkg
//  DATA_W    BYTE_WIDTH*BYTES_PER_BLOCK      block value width, from oram_functions_pkg
//  TIMEOUT   15                              max WAIT cycles before an error response
// PORTS
//  clk                 in   1               core clock, rising edge
//  rst                 in   1               asynchronous reset, active high
//  req_valid           in   NUM_REQ         per-requester request valid
//  req_rw              in   NUM_REQ         per-requester op: 0=read, 1=write
//  req_addr            in   NUM_REQ*ADDR_W  per-requester block number, packed, req i at [i*ADDR_W +: ADDR_W]
//  req_wdata           in   NUM_REQ*DATA_W  per-requester write value, packed likewise
//  req_ready           out  NUM_REQ         one-hot accept pulse
//  rsp_valid           out  NUM_REQ         one-hot response pulse, 1 cycle
//  rsp_rdata           out  DATA_W          read data, valid with rsp_valid; 0 for writes
//  rsp_err             out  1               timeout flag, valid with rsp_valid
//  busy                out  1               transaction in flight (state != IDLE)
//  oram_block_number   out  ADDR_W          to ORAM rw_block_number
//  oram_w_value        out  DATA_W          to ORAM w_value
//  oram_rw_indicator   out  1               to ORAM rw_indicator
//  oram_input_ready    out  1               to ORAM input_ready
//  oram_r_value        in   DATA_W          from ORAM r_value
//  oram_output_ready   in   1               from ORAM output_ready
// BEHAVIOUR
//  - Reset (async): state=IDLE, rr_ptr=0, and every output, ORAM-side outputs included, is 0.
//  - FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. All outputs are registered.
//  - IDLE, any req_valid: the grant goes to the first set bit searching from rr_ptr upward, modulo NUM_REQ.
//    - In the same cycle: req_ready[g]=1 (combinational from the registered state plus req_valid).
//    - Capture addr/wdata/rw into the command register. Go to ISSUE. rr_ptr <= (g+1) mod NUM_REQ.
//  - ISSUE (1 cycle): oram_input_ready=1 and oram_* driven from the command register. Go to WAIT.
//  - Command register contents stay stable on oram_* from ISSUE through RESP. oram_input_ready is 1 only in ISSUE.
//  - WAIT: the ORAM output_ready is sticky, so a completion is recognised only in a WAIT cycle where oram_output_ready=1.
//    - On completion: latch oram_r_value (reads) or 0 (writes), err=0, go to RESP.
//    - Else a timer of width clog2(TIMEOUT+1) increments. When it reaches TIMEOUT: err=1, data=0, go to RESP.
//    - The timer clears on entry to WAIT.
//  - RESP (1 cycle): rsp_valid[g]=1 with rsp_rdata/rsp_err. Go to IDLE.
//    - The next grant can occur in the IDLE cycle that follows.
//    - Minimum request-to-response latency is 3 cycles (accept, ISSUE, WAIT, RESP).
//  - A requester must hold its valid and payload until req_ready. Valid dropped early is simply not granted; this is not an error.
//  - req_valid seen outside IDLE is ignored, and req_ready stays 0 there.
//  - Several simultaneous valids: only one is granted per transaction, and the rotation guarantees no starvation.
//  - rst during ISSUE/WAIT/RESP: the transaction is abandoned and no rsp_valid is produced. Requesters must reissue.
//  - NUM_REQ=1 degenerates to pass-through sequencing with rr_ptr fixed at 0.
// STRUCTURE
//  - oram_functions_pkg gains:
//    - typedef arb_state_e {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP}
//    - typedef oram_cmd_t {rw, addr, wdata}
//    - localparam ARB_TIMEOUT_DEFAULT=15
//  - One sub-module: oram_rr_picker, a combinational rotate-priority-encoder.
//    - Inputs req vector and rr_ptr; outputs grant index and any_valid.
//    - FSM, command register and timer stay in the top.
// TESTING
//  - Single read: req_valid=0001, rw=0, addr=3; the ORAM model asserts output_ready in WAIT with r_value=0xAB.
//    -> rsp_valid=0001 and rsp_rdata=0xAB, 3 cycles after accept.
//  - Write then read: req 2 writes 0x5A to block 1, then req 2 reads block 1.
//    -> the write response gives rsp_rdata=0 and err=0; the read returns 0x5A.
//  - Contention: req_valid=1111 held.
//    -> grants in the order 0,1,2,3,0 with exactly one req_ready per transaction.
//  - Contention after rotation: rr_ptr=2 with req_valid=0011 -> grant 0.
//  - Timeout: the model holds output_ready=0.
//    -> rsp_err=1 and rsp_rdata=0 after 15 WAIT cycles, and the arbiter then accepts again.
//  - Reset mid-WAIT: assert rst asynchronously.
//    -> all outputs 0 immediately, no rsp_valid, busy=0; a subsequent request is granted to the rr_ptr=0 winner.

Source files
------------

// File: rtl/oram_functions_pkg.sv
// Shared ORAM geometry plus the types used by the request arbiter.
package oram_functions_pkg;

    localparam int unsigned TREE_DEPTH          = 4;
    localparam int unsigned BYTE_WIDTH          = 8;
    localparam int unsigned BYTES_PER_BLOCK     = 4;
    localparam int unsigned ORAM_ADDR_W         = TREE_DEPTH;
    localparam int unsigned ORAM_DATA_W         = BYTE_WIDTH * BYTES_PER_BLOCK;
    localparam int unsigned ARB_TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_RESP
    } arb_state_e;

    typedef struct packed {
        logic                   rw;
        logic [ORAM_ADDR_W-1:0] addr;
        logic [ORAM_DATA_W-1:0] wdata;
    } oram_cmd_t;

endpackage

// File: rtl/oram_request_arbiter_if.sv
// Requester-side and ORAM-side signal bundle of the request arbiter.
interface oram_request_arbiter_if
    import oram_functions_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = ORAM_ADDR_W,
    parameter int unsigned DATA_W  = ORAM_DATA_W
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_rw;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic                      busy;
    logic [ADDR_W-1:0]         oram_block_number;
    logic [DATA_W-1:0]         oram_w_value;
    logic                      oram_rw_indicator;
    logic                      oram_input_ready;
    logic [DATA_W-1:0]         oram_r_value;
    logic                      oram_output_ready;

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata, oram_r_value, oram_output_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               oram_block_number, oram_w_value, oram_rw_indicator, oram_input_ready
    );

    modport master (
        output req_valid, req_rw, req_addr, req_wdata, oram_r_value, oram_output_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               oram_block_number, oram_w_value, oram_rw_indicator, oram_input_ready
    );

endinterface

// File: rtl/oram_rr_picker.sv
// Rotating priority encoder: first set request bit at or above rr_ptr, wrapping.
module oram_rr_picker #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               any_valid
);

    int unsigned pos;

    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        pos       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = 32'(rr_ptr) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            if (!any_valid && req[IDX_W'(pos)]) begin
                grant     = IDX_W'(pos);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/oram_request_arbiter.sv
// Round-robin arbiter sharing one ORAM core between NUM_REQ requesters,
// one transaction in flight, with a WAIT timeout that returns an error response.
module oram_request_arbiter
    import oram_functions_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = ORAM_ADDR_W,
    parameter int unsigned DATA_W  = ORAM_DATA_W,
    parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input logic                   clk,
    input logic                   rst,
    oram_request_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    oram_cmd_t          cmd_q, cmd_d;
    logic [TMR_W-1:0]   timer_q, timer_d, timer_inc;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;
    logic               busy_q, busy_d;
    logic               input_ready_q, input_ready_d;
    logic [NUM_REQ-1:0] req_ready_c;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = bus.req_addr[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i] = bus.req_wdata[i*DATA_W +: DATA_W];
    end

    oram_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req       (bus.req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (pick_idx),
        .any_valid (pick_any)
    );

    assign timer_inc = timer_q + TMR_W'(1);

    // Next state plus next values of every registered output.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        cmd_d         = cmd_q;
        timer_d       = timer_q;
        rsp_valid_d   = '0;
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b0;
        input_ready_d = 1'b0;
        req_ready_c   = '0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any && !rst) begin
                    req_ready_c[pick_idx] = 1'b1;
                    grant_d       = pick_idx;
                    cmd_d.rw      = bus.req_rw[pick_idx];
                    cmd_d.addr    = ORAM_ADDR_W'(addr_arr[pick_idx]);
                    cmd_d.wdata   = ORAM_DATA_W'(wdata_arr[pick_idx]);
                    rr_ptr_d      = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
                    input_ready_d = 1'b1;
                    state_d       = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                timer_d = '0;
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                // output_ready is sticky on the ORAM side, so it only counts here.
                if (bus.oram_output_ready) begin
                    rsp_valid_d[grant_q] = 1'b1;
                    rsp_rdata_d          = cmd_q.rw ? '0 : bus.oram_r_value;
                    state_d              = ARB_RESP;
                end else begin
                    timer_d = timer_inc;
                    if (timer_inc == TMR_W'(TIMEOUT)) begin
                        rsp_valid_d[grant_q] = 1'b1;
                        rsp_err_d            = 1'b1;
                        state_d              = ARB_RESP;
                    end
                end
            end
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
        busy_d = (state_d != ARB_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ARB_IDLE;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            cmd_q         <= '0;
            timer_q       <= '0;
            rsp_valid_q   <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            busy_q        <= 1'b0;
            input_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_q       <= grant_d;
            cmd_q         <= cmd_d;
            timer_q       <= timer_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            busy_q        <= busy_d;
            input_ready_q <= input_ready_d;
        end
    end

    assign bus.req_ready         = req_ready_c;
    assign bus.rsp_valid         = rsp_valid_q;
    assign bus.rsp_rdata         = rsp_rdata_q;
    assign bus.rsp_err           = rsp_err_q;
    assign bus.busy              = busy_q;
    assign bus.oram_block_number = ADDR_W'(cmd_q.addr);
    assign bus.oram_w_value      = DATA_W'(cmd_q.wdata);
    assign bus.oram_rw_indicator = cmd_q.rw;
    assign bus.oram_input_ready  = input_ready_q;

endmodule

// File: tb/tb_oram_request_arbiter.sv
// Scoreboard bench for oram_request_arbiter with a behavioural ORAM responder.
module tb_oram_request_arbiter;
    import oram_functions_pkg::*;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = ORAM_ADDR_W;
    localparam int unsigned DW = ORAM_DATA_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    oram_request_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    oram_request_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int            g;
        logic [DW-1:0] data;
        logic          err;
        int            lat;
    } rsp_t;

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    int   exp_grant[$];
    rsp_t exp_rsp[$];
    cmd_t exp_cmd[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int accept_cyc = 0;
    int model_k  = 0;
    int model_cnt = 0;
    logic [DW-1:0] mem [16];

    int            mon_g;
    rsp_t          mon_r;
    cmd_t          mon_c;
    logic [NR-1:0] mon_oh;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ORAM responder: output_ready rises model_k negedges after ISSUE and stays up; model_k<0 never answers.
    always @(negedge clk) begin
        if (bus.oram_input_ready) begin
            if (bus.oram_rw_indicator) begin
                mem[bus.oram_block_number] = bus.oram_w_value;
                bus.oram_r_value = 32'hDEAD_BEEF;
            end else begin
                bus.oram_r_value = mem[bus.oram_block_number];
            end
            model_cnt = model_k;
            bus.oram_output_ready = (model_k == 0);
        end else if (!bus.oram_output_ready && model_cnt > 0) begin
            model_cnt--;
            if (model_cnt == 0) bus.oram_output_ready = 1'b1;
        end
    end

    // Monitor: pops expectations whenever the DUT presents a grant, a command or a response.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (bus.req_ready != '0) begin
                if (exp_grant.size() == 0) begin
                    check("unexpected_grant", 64'(bus.req_ready), 64'(0));
                end else begin
                    mon_g  = exp_grant.pop_front();
                    mon_oh = NR'(1) << mon_g;
                    check("grant", 64'(bus.req_ready), 64'(mon_oh));
                    accept_cyc = cyc;
                end
            end
            if (bus.oram_input_ready) begin
                if (exp_cmd.size() == 0) begin
                    check("unexpected_issue", 64'(bus.oram_input_ready), 64'(0));
                end else begin
                    mon_c = exp_cmd.pop_front();
                    check("oram_rw", 64'(bus.oram_rw_indicator), 64'(mon_c.rw));
                    check("oram_addr", 64'(bus.oram_block_number), 64'(mon_c.addr));
                    check("oram_wdata", 64'(bus.oram_w_value), 64'(mon_c.wdata));
                end
            end
            if (bus.rsp_valid != '0) begin
                if (exp_rsp.size() == 0) begin
                    check("unexpected_rsp", 64'(bus.rsp_valid), 64'(0));
                end else begin
                    mon_r  = exp_rsp.pop_front();
                    mon_oh = NR'(1) << mon_r.g;
                    check("rsp_valid", 64'(bus.rsp_valid), 64'(mon_oh));
                    check("rsp_rdata", 64'(bus.rsp_rdata), 64'(mon_r.data));
                    check("rsp_err", 64'(bus.rsp_err), 64'(mon_r.err));
                    check("rsp_latency", 64'(cyc - accept_cyc), 64'(mon_r.lat));
                end
            end
        end
    end

    task automatic set_req(input int i, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_rw[i] = rw;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    task automatic expect_txn(input int g, input logic rw, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                              input logic err, input int lat);
        rsp_t r;
        cmd_t c;
        exp_grant.push_back(g);
        c.rw = rw; c.addr = a; c.wdata = wd;
        exp_cmd.push_back(c);
        r.g = g; r.data = rd; r.err = err; r.lat = lat;
        exp_rsp.push_back(r);
    endtask

    // Called at a negedge with valids already driven; drops all valids after n grants.
    task automatic hold_until(input int n);
        int got = 0;
        for (int c = 0; c < 300; c++) begin
            #1;
            if (bus.req_ready != '0) got++;
            if (got == n) break;
            @(negedge clk);
        end
        if (got != n) begin
            n_checks++; n_fail++;
            $display("FAIL grant_wait: got %0d grants, expected %0d", got, n);
        end
        @(negedge clk);
        bus.req_valid = '0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #3;
            if (exp_rsp.size() == 0 && bus.busy == 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL idle_wait: got %0d pending responses, expected 0", exp_rsp.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = '0;
        bus.req_rw    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.oram_r_value      = '0;
        bus.oram_output_ready = 1'b0;
        for (int k = 0; k < 16; k++) mem[k] = DW'(32'hC0 + k);
        mem[3] = 32'hAB;

        // Reset state; a valid held during reset must not be accepted.
        repeat (3) @(negedge clk);
        set_req(0, 1'b0, 4'd3, 32'h0);
        bus.req_valid = 4'b0001;
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'(0));
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_input_ready", 64'(bus.oram_input_ready), 64'(0));
        check("rst_block_number", 64'(bus.oram_block_number), 64'(0));
        check("rst_rdata", 64'(bus.rsp_rdata), 64'(0));

        // Single read of block 3 by req 0.
        model_k = 0;
        expect_txn(0, 1'b0, 4'd3, 32'h0, 32'hAB, 1'b0, 3);
        @(negedge clk);
        rst = 1'b0;
        hold_until(1);
        wait_idle();

        // Req 2 writes 0x5A to block 1 with a slow ORAM, then reads it back.
        model_k = 3;
        expect_txn(2, 1'b1, 4'd1, 32'h5A, 32'h0, 1'b0, 5);
        @(negedge clk);
        set_req(2, 1'b1, 4'd1, 32'h5A);
        bus.req_valid = 4'b0100;
        hold_until(1);
        wait_idle();
        model_k = 0;
        expect_txn(2, 1'b0, 4'd1, 32'h0, 32'h5A, 1'b0, 3);
        @(negedge clk);
        set_req(2, 1'b0, 4'd1, 32'h0);
        bus.req_valid = 4'b0100;
        hold_until(1);
        wait_idle();

        // Req 3 alone moves the pointer back to 0.
        expect_txn(3, 1'b0, 4'd5, 32'h0, 32'hC5, 1'b0, 3);
        @(negedge clk);
        set_req(3, 1'b0, 4'd5, 32'h0);
        bus.req_valid = 4'b1000;
        hold_until(1);
        wait_idle();

        // Full contention held for five transactions: 0,1,2,3,0.
        expect_txn(0, 1'b0, 4'd0, 32'h0, 32'hC0, 1'b0, 3);
        expect_txn(1, 1'b0, 4'd1, 32'h0, 32'h5A, 1'b0, 3);
        expect_txn(2, 1'b0, 4'd2, 32'h0, 32'hC2, 1'b0, 3);
        expect_txn(3, 1'b0, 4'd3, 32'h0, 32'hAB, 1'b0, 3);
        expect_txn(0, 1'b0, 4'd0, 32'h0, 32'hC0, 1'b0, 3);
        @(negedge clk);
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, AW'(i), 32'h0);
        bus.req_valid = 4'b1111;
        hold_until(5);
        wait_idle();

        // Req 1 alone leaves rr_ptr=2; then 0011 must grant 0 before 1.
        expect_txn(1, 1'b0, 4'd6, 32'h0, 32'hC6, 1'b0, 3);
        @(negedge clk);
        set_req(1, 1'b0, 4'd6, 32'h0);
        bus.req_valid = 4'b0010;
        hold_until(1);
        wait_idle();
        expect_txn(0, 1'b0, 4'd0, 32'h0, 32'hC0, 1'b0, 3);
        expect_txn(1, 1'b0, 4'd2, 32'h0, 32'hC2, 1'b0, 3);
        @(negedge clk);
        set_req(0, 1'b0, 4'd0, 32'h0);
        set_req(1, 1'b0, 4'd2, 32'h0);
        bus.req_valid = 4'b0011;
        hold_until(2);
        wait_idle();

        // Timeout: no completion, error after 15 WAIT cycles, then normal service resumes.
        model_k = -1;
        expect_txn(1, 1'b0, 4'd2, 32'h0, 32'h0, 1'b1, 17);
        @(negedge clk);
        set_req(1, 1'b0, 4'd2, 32'h0);
        bus.req_valid = 4'b0010;
        hold_until(1);
        wait_idle();
        model_k = 0;
        expect_txn(3, 1'b0, 4'd7, 32'h0, 32'hC7, 1'b0, 3);
        @(negedge clk);
        set_req(3, 1'b0, 4'd7, 32'h0);
        bus.req_valid = 4'b1000;
        hold_until(1);
        wait_idle();

        // Reset in the middle of WAIT abandons the transaction.
        model_k = -1;
        exp_grant.push_back(2);
        mon_c.rw = 1'b0; mon_c.addr = 4'd9; mon_c.wdata = 32'h0;
        exp_cmd.push_back(mon_c);
        @(negedge clk);
        set_req(2, 1'b0, 4'd9, 32'h0);
        bus.req_valid = 4'b0100;
        hold_until(1);
        repeat (3) @(negedge clk);
        #1;
        check("busy_in_wait", 64'(bus.busy), 64'(1));
        @(posedge clk);
        #2;
        rst = 1'b1;
        set_req(1, 1'b0, 4'd0, 32'h0);
        set_req(3, 1'b0, 4'd4, 32'h0);
        bus.req_valid = 4'b1010;
        #1;
        check("midrst_req_ready", 64'(bus.req_ready), 64'(0));
        check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("midrst_busy", 64'(bus.busy), 64'(0));
        check("midrst_input_ready", 64'(bus.oram_input_ready), 64'(0));
        check("midrst_block_number", 64'(bus.oram_block_number), 64'(0));
        check("midrst_rw", 64'(bus.oram_rw_indicator), 64'(0));
        check("midrst_w_value", 64'(bus.oram_w_value), 64'(0));
        check("midrst_rdata", 64'(bus.rsp_rdata), 64'(0));
        check("midrst_err", 64'(bus.rsp_err), 64'(0));

        // After reset rr_ptr is 0 again, so 1010 grants req 1.
        model_k = 0;
        expect_txn(1, 1'b0, 4'd0, 32'h0, 32'hC0, 1'b0, 3);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hold_until(1);
        wait_idle();

        repeat (3) @(negedge clk);
        check("queues_empty", 64'(exp_grant.size() + exp_rsp.size() + exp_cmd.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
